// File: rtl/spi_arbiter.sv
// Round-robin arbiter that shares one SPI sequencer between N_REQ requesters.
// It grants one command at a time, returns its read byte and aborts a hung transfer after TIMEOUT cycles.

module spi_arbiter_lane (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sel,
  input  logic fire,
  input  logic tmo,
  input  logic clr,
  output logic ack,
  output logic err
);
  always_ff @(posedge clk_i) begin
    if (rst_i || clr) begin
      ack <= 1'b0;
      err <= 1'b0;
    end else if (fire && sel) begin
      ack <= 1'b1;
      err <= tmo;
    end
  end
endmodule

module spi_arbiter #(
  parameter int N_REQ   = 3,
  parameter int TIMEOUT = 200000
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [N_REQ-1:0]      req_i,
  input  logic [16*N_REQ-1:0]   cmd_i,
  output logic [N_REQ-1:0]      ack_o,
  output logic [N_REQ-1:0]      err_o,
  output logic [7:0]            rdata_o,
  output logic                  busy_o,
  output logic [1:0]            grant_o,
  output logic                  seq_req_o,
  output logic [15:0]           seq_cmd_o,
  input  logic                  seq_ack_i,
  input  logic [7:0]            seq_rdata_i
);
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      cmd_d;
  logic [7:0]       rdata_d;
  logic [1:0]       grant_d;
  logic             seq_req_d;
  logic             fire, tmo;
  logic [2:0]       pick;

  // Returns {found, index}; scanning downward lets the smallest offset from p win.
  function automatic logic [2:0] rr_pick(input logic [N_REQ-1:0] req, input logic [1:0] p);
    logic [2:0] r;
    int k;
    r = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      k = (int'(p) + i) % N_REQ;
      if (req[k]) r = {1'b1, 2'(k)};
    end
    return r;
  endfunction

  assign pick   = rr_pick(req_i, ptr_q);
  assign busy_o = (state_q != IDLE);

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    cmd_d     = seq_cmd_o;
    rdata_d   = rdata_o;
    grant_d   = grant_o;
    seq_req_d = seq_req_o;
    fire      = 1'b0;
    tmo       = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick[2]) begin
          grant_d   = pick[1:0];
          cmd_d     = cmd_i[16*int'(pick[1:0]) +: 16];
          seq_req_d = 1'b1;
          cnt_d     = '0;
          ptr_d     = (pick[1:0] == 2'(N_REQ - 1)) ? 2'd0 : pick[1:0] + 2'd1;
          state_d   = BUSY;
        end
      end
      BUSY: begin
        // A real ack on the timeout edge takes precedence over the abort.
        if (seq_ack_i) begin
          rdata_d   = seq_rdata_i;
          seq_req_d = 1'b0;
          fire      = 1'b1;
          state_d   = DONE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          rdata_d   = 8'h00;
          seq_req_d = 1'b0;
          fire      = 1'b1;
          tmo       = 1'b1;
          state_d   = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      cnt_q     <= '0;
      seq_cmd_o <= '0;
      rdata_o   <= '0;
      grant_o   <= '0;
      seq_req_o <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      seq_cmd_o <= cmd_d;
      rdata_o   <= rdata_d;
      grant_o   <= grant_d;
      seq_req_o <= seq_req_d;
    end
  end

  for (genvar k = 0; k < N_REQ; k++) begin : g_lane
    spi_arbiter_lane u_lane (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .sel   (grant_o == 2'(k)),
      .fire  (fire),
      .tmo   (tmo),
      .clr   (state_q == DONE),
      .ack   (ack_o[k]),
      .err   (err_o[k])
    );
  end
endmodule
